// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared state encoding and defaults for the sequential divider
package alu_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Every quotient bit takes this value on a divide by zero
  localparam logic DIV_ZERO_QUO_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one restoring-division step: trial subtract of the divisor from R'
module alu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r_shift,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_r_next,
  output logic             o_q_bit
);

  logic             w_carry_lo;
  logic [WIDTH-1:0] w_diff;
  logic             w_carry;

  assign {w_carry_lo, w_diff} = {1'b0, i_r_shift[WIDTH-1:0]} + {1'b0, ~i_divisor} + {{WIDTH{1'b0}}, 1'b1};
  // MSB column adds R'[WIDTH] to the inverted zero pad (1); no borrow means T >= 0
  assign w_carry  = i_r_shift[WIDTH] | w_carry_lo;
  assign o_q_bit  = w_carry;
  assign o_r_next = w_carry ? w_diff : i_r_shift[WIDTH-1:0];

endmodule

// File: rtl/alu_seq_divider.sv
// rtl/alu_seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// ALU_DIV_SIGNED_EN selects two's-complement operands with a sign-fix state.
module alu_seq_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;

  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH-1:0] w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_dvd_load;
  logic [WIDTH-1:0] w_dvs_load;
  logic             w_last;

`ifdef ALU_DIV_SIGNED_EN
  logic r_sign_q;
  logic r_sign_r;
  assign w_dvd_load = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign w_dvs_load = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
`else
  assign w_dvd_load = dividend_i;
  assign w_dvs_load = divisor_i;
`endif

  assign w_r_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_quo_next = {r_quo[WIDTH-2:0], w_q_bit};
  assign w_last     = (r_cnt == LAST_CNT);

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .i_r_shift (w_r_shift),
    .i_divisor (r_div),
    .o_r_next  (w_r_next),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start_i) w_state_nxt = (divisor_i == '0) ? DONE : RUN;
`ifdef ALU_DIV_SIGNED_EN
      RUN:  if (w_last) w_state_nxt = FIX;
`else
      RUN:  if (w_last) w_state_nxt = DONE;
`endif
      FIX:  w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_rem <= '0;
          r_quo <= w_dvd_load;
          r_div <= w_dvs_load;
          r_cnt <= '0;
`ifdef ALU_DIV_SIGNED_EN
          r_sign_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
          r_sign_r <= dividend_i[WIDTH-1];
`endif
          // Zero divisor skips RUN, so its results are published right here
          if (divisor_i == '0) begin
            r_quotient  <= {WIDTH{DIV_ZERO_QUO_BIT}};
            r_remainder <= dividend_i;
            r_div_zero  <= 1'b1;
          end
        end
        RUN: begin
          r_rem <= w_r_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CNT_W'(1);
`ifndef ALU_DIV_SIGNED_EN
          if (w_last) begin
            r_quotient  <= w_quo_next;
            r_remainder <= w_r_next;
            r_div_zero  <= 1'b0;
          end
`endif
        end
`ifdef ALU_DIV_SIGNED_EN
        FIX: begin
          r_quotient  <= r_sign_q ? -r_quo : r_quo;
          r_remainder <= r_sign_r ? -r_rem : r_rem;
          r_div_zero  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state == RUN) || (r_state == FIX);
  assign done_o      = (r_state == DONE);
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;
  assign div_zero_o  = r_div_zero;

endmodule

// File: tb/tb_alu_seq_divider.sv
// tb/tb_alu_seq_divider.sv - directed self-checking bench for alu_seq_divider
module tb_alu_seq_divider;

`ifdef ALU_DIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_zero_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_divider dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
  endtask

  // lat0 is the cycle index (relative to the accepting edge) already reached
  task automatic finish_div(input string tag, input int lat0, input int exp_lat,
                            input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int lat;
    int busy_n;
    lat = lat0;
    busy_n = 0;
    while (done_o !== 1'b1 && lat < 200) begin
      if (busy_o === 1'b1) busy_n++;
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, busy_n, exp_lat - lat0);
    check({tag, ".quotient"}, quotient_o, eq);
    check({tag, ".remainder"}, remainder_o, er);
    check({tag, ".div_zero"}, {31'd0, div_zero_o}, {31'd0, ez});
    check({tag, ".busy_at_done"}, {31'd0, busy_o}, 32'd0);
    step();
    check({tag, ".done_pulse_ends"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int done_n;

    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    check("reset.busy", {31'd0, busy_o}, 32'd0);
    check("reset.done", {31'd0, done_o}, 32'd0);
    check("reset.quotient", quotient_o, 32'd0);
    check("reset.remainder", remainder_o, 32'd0);
    check("reset.div_zero", {31'd0, div_zero_o}, 32'd0);

    launch(32'd100, 32'd7);
    finish_div("basic_100_7", 1, LAT, 32'd14, 32'd2, 1'b0);

    launch(32'h0000_1234, 32'd0);
    finish_div("div_zero", 1, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

    launch(32'd100, 32'd7);
    for (int i = 0; i < 9; i++) step();
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
    finish_div("start_while_busy", 11, LAT, 32'd14, 32'd2, 1'b0);

    launch(32'd50, 32'd5);
    finish_div("back_to_back", 1, LAT, 32'd10, 32'd0, 1'b0);

    launch(32'd100, 32'd7);
    for (int i = 0; i < 14; i++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midreset.busy", {31'd0, busy_o}, 32'd0);
    check("midreset.done", {31'd0, done_o}, 32'd0);
    check("midreset.quotient", quotient_o, 32'd0);
    check("midreset.remainder", remainder_o, 32'd0);
    check("midreset.div_zero", {31'd0, div_zero_o}, 32'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o !== 1'b0) done_n++;
      step();
    end
    check("midreset.no_done", done_n, 32'd0);

    launch(32'hFFFF_FFFF, 32'd1);
    finish_div("all_ones_by_1", 1, LAT, 32'hFFFF_FFFF, 32'd0, 1'b0);

`ifdef ALU_DIV_SIGNED_EN
    launch(32'hFFFF_FFF9, 32'd2);
    finish_div("neg7_by_2", 1, LAT, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    finish_div("overflow", 1, LAT, 32'h8000_0000, 32'd0, 1'b0);
    launch(32'hFFFF_FFF9, 32'd0);
    finish_div("neg_div_zero", 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`else
    launch(32'hFFFF_FFF9, 32'd2);
    finish_div("big_by_2", 1, LAT, 32'h7FFF_FFFC, 32'd1, 1'b0);
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    finish_div("small_by_big", 1, LAT, 32'd0, 32'h8000_0000, 1'b0);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_div("equal_operands", 1, LAT, 32'd1, 32'd0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
